// File: rtl/sram_sched_pkg.sv
// Shared types and constants for the SRAM block-transfer scheduler.
package sram_sched_pkg;

    localparam int unsigned MEM_WORDS   = 4000;
    localparam int unsigned BLOCK_WORDS = 100;
    localparam int unsigned BLK_W       = 10;
    localparam int unsigned ADDR_W      = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HOLD,
        ST_START,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } state_t;

    // True when a whole block starting at addr lies inside MIX memory.
    function automatic logic block_fits(input logic [ADDR_W-1:0] addr,
                                        input int unsigned        words,
                                        input int unsigned        mem_words);
        return (32'(addr) + words) <= mem_words;
    endfunction

endpackage

// File: rtl/sram_block_sched_rr_pick.sv
// Combinational round-robin selector: search starts at ptr+1 and wraps.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic [IW-1:0] c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            c = IW'((32'(ptr) + k) % N);
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = c;
            end
        end
    end

endmodule

// File: rtl/sram_block_sched.sv
// Shares the SRAM block engine among MIX I/O units; optional RUN watchdog
// enabled by defining SRAM_ARB_WATCHDOG_EN.
module sram_block_sched #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned MEM_WORDS   = sram_sched_pkg::MEM_WORDS,
    parameter int unsigned BLOCK_WORDS = sram_sched_pkg::BLOCK_WORDS
`ifdef SRAM_ARB_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT     = 1023
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_dir,
    input  logic [10*NREQ-1:0] req_block,
    input  logic [12*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   busy,
    output logic [NREQ-1:0]   done,
    output logic [NREQ-1:0]   err,
    output logic              cpu_hold,
    input  logic              cpu_idle,
    output logic              eng_start_w,
    output logic              eng_start_r,
    output logic [9:0]        eng_block,
    output logic [11:0]       eng_addr,
    input  logic              eng_stop,
    output logic              eng_abort
);
    import sram_sched_pkg::*;

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    logic [IW-1:0]     ptr;
    logic              dir;
    logic [NREQ-1:0]   err_next;

    logic [NREQ-1:0]   avail;
    logic [NREQ-1:0]   pick_grant;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic [BLK_W-1:0]  sel_block;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_dir;
    logic              sel_ok;

    // A unit sees req_ready one cycle late, so its still-high valid is masked.
    assign avail = req_valid & ~req_ready;

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_pick (
        .req   (avail),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    always_comb begin
        sel_block = '0;
        sel_addr  = '0;
        sel_dir   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                sel_block = req_block[i*BLK_W +: BLK_W];
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_dir   = req_dir[i];
            end
        end
    end

    assign sel_ok = block_fits(sel_addr, BLOCK_WORDS, MEM_WORDS);

`ifdef SRAM_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            abort_q;
    assign eng_abort = abort_q;
`else
    assign eng_abort = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ptr         <= IW'(NREQ - 1);
            dir         <= 1'b0;
            err_next    <= '0;
            req_ready   <= '0;
            busy        <= '0;
            done        <= '0;
            err         <= '0;
            cpu_hold    <= 1'b0;
            eng_start_w <= 1'b0;
            eng_start_r <= 1'b0;
            eng_block   <= '0;
            eng_addr    <= '0;
`ifdef SRAM_ARB_WATCHDOG_EN
            wd_cnt      <= '0;
            abort_q     <= 1'b0;
`endif
        end else begin
            req_ready   <= '0;
            done        <= '0;
            err         <= err_next;
            err_next    <= '0;
            eng_start_w <= 1'b0;
            eng_start_r <= 1'b0;
`ifdef SRAM_ARB_WATCHDOG_EN
            abort_q     <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        req_ready <= pick_grant;
                        ptr       <= pick_idx;
                        dir       <= sel_dir;
                        eng_block <= sel_block;
                        eng_addr  <= sel_addr;
                        if (sel_ok) begin
                            busy     <= pick_grant;
                            cpu_hold <= 1'b1;
                            state    <= ST_HOLD;
                        end else begin
                            err_next <= pick_grant;
                        end
                    end
                end
                ST_HOLD: begin
                    // The accept cycle is not counted; cpu_idle is honoured from the next cycle.
                    if (cpu_idle && (req_ready == '0)) begin
                        eng_start_w <= dir;
                        eng_start_r <= ~dir;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
`ifdef SRAM_ARB_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (eng_stop) begin
                        done     <= busy;
                        busy     <= '0;
                        cpu_hold <= 1'b0;
                        state    <= ST_DONE;
                    end
`ifdef SRAM_ARB_WATCHDOG_EN
                    else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        abort_q  <= 1'b1;
                        err      <= busy;
                        busy     <= '0;
                        cpu_hold <= 1'b0;
                        state    <= ST_ABORT;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_block_sched.sv
// Bench for sram_block_sched: directed scenarios plus randomized traffic against a transaction-timing model.
module tb_sram_block_sched;

    localparam int NREQ        = 4;
    localparam int MEM_WORDS   = 4000;
    localparam int BLOCK_WORDS = 100;
`ifdef SRAM_ARB_WATCHDOG_EN
    localparam int TIMEOUT     = 1023;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req_valid, req_dir, req_ready, busy, done, err;
    logic [10*NREQ-1:0] req_block;
    logic [12*NREQ-1:0] req_addr;
    logic              cpu_hold, cpu_idle, eng_start_w, eng_start_r, eng_stop, eng_abort;
    logic [9:0]        eng_block;
    logic [11:0]       eng_addr;

    logic [9:0]  u_blk  [NREQ];
    logic [11:0] u_addr [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_block[i*10 +: 10] = u_blk[i];
            req_addr[i*12 +: 12]  = u_addr[i];
        end
    end

    sram_block_sched #(
        .NREQ        (NREQ),
        .MEM_WORDS   (MEM_WORDS),
        .BLOCK_WORDS (BLOCK_WORDS)
`ifdef SRAM_ARB_WATCHDOG_EN
        , .TIMEOUT   (TIMEOUT)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_dir     (req_dir),
        .req_block   (req_block),
        .req_addr    (req_addr),
        .req_ready   (req_ready),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cpu_hold    (cpu_hold),
        .cpu_idle    (cpu_idle),
        .eng_start_w (eng_start_w),
        .eng_start_r (eng_start_r),
        .eng_block   (eng_block),
        .eng_addr    (eng_addr),
        .eng_stop    (eng_stop),
        .eng_abort   (eng_abort)
    );

    int checks   = 0;
    int failures = 0;

    // Model: expected outputs of the current cycle plus transfer bookkeeping.
    logic [NREQ-1:0] e_ready, e_busy, e_done, e_err, err_stage;
    logic            e_hold, e_sw, e_sr, e_abort;
    logic [9:0]      e_blk;
    logic [11:0]     e_addr;
    int              owner = -1;
    int              m_ptr = NREQ - 1;
    int              launch_cyc, run_cnt;
    int              cyc = 0;
    bit              launched, m_dir;

    bit auto_eng = 0;
    bit rereq0   = 0;
    int stop_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Predict the outputs of the next cycle from the inputs present now.
    task automatic predict();
        logic [NREQ-1:0] avail, cur_ready;
        bit free_now, found;
        int g, i;
        if (reset) begin
            e_ready = '0; e_busy = '0; e_done = '0; e_err = '0; err_stage = '0;
            e_hold = 1'b0; e_sw = 1'b0; e_sr = 1'b0; e_abort = 1'b0;
            e_blk = '0; e_addr = '0;
            owner = -1; m_ptr = NREQ - 1; launched = 0;
            cyc++;
            return;
        end
        cur_ready = e_ready;
        free_now  = (owner < 0) && (e_done == '0) && !e_abort;
        avail     = req_valid & ~cur_ready;
        e_ready = '0; e_done = '0; e_sw = 1'b0; e_sr = 1'b0; e_abort = 1'b0;
        e_err = err_stage; err_stage = '0;
        if (free_now && avail != '0) begin
            found = 0; g = 0;
            for (int k = 1; k <= NREQ; k++) begin
                i = (m_ptr + k) % NREQ;
                if (!found && avail[i]) begin found = 1; g = i; end
            end
            e_ready[g] = 1'b1;
            m_ptr  = g;
            e_blk  = u_blk[g];
            e_addr = u_addr[g];
            m_dir  = req_dir[g];
            if (int'(u_addr[g]) + BLOCK_WORDS <= MEM_WORDS) begin
                owner = g; e_busy[g] = 1'b1; e_hold = 1'b1; launched = 0;
            end else begin
                err_stage[g] = 1'b1;
            end
        end else if (owner >= 0) begin
            if (!launched) begin
                if (cur_ready == '0 && cpu_idle) begin
                    launched = 1; launch_cyc = cyc + 1; run_cnt = 0;
                    if (m_dir) e_sw = 1'b1; else e_sr = 1'b1;
                end
            end else if (cyc > launch_cyc) begin
                if (eng_stop) begin
                    e_done[owner] = 1'b1; e_busy = '0; e_hold = 1'b0; owner = -1;
                end
`ifdef SRAM_ARB_WATCHDOG_EN
                else begin
                    run_cnt++;
                    if (run_cnt == TIMEOUT) begin
                        e_abort = 1'b1; e_err[owner] = 1'b1;
                        e_busy = '0; e_hold = 1'b0; owner = -1;
                    end
                end
`endif
            end
        end
        cyc++;
    endtask

    task automatic compare();
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("err", 32'(err), 32'(e_err));
        chk("cpu_hold", 32'(cpu_hold), 32'(e_hold));
        chk("eng_start_w", 32'(eng_start_w), 32'(e_sw));
        chk("eng_start_r", 32'(eng_start_r), 32'(e_sr));
        chk("eng_abort", 32'(eng_abort), 32'(e_abort));
        if (e_hold) begin
            chk("eng_block", 32'(eng_block), 32'(e_blk));
            chk("eng_addr", 32'(eng_addr), 32'(e_addr));
        end
    endtask

    task automatic react();
        for (int i = 0; i < NREQ; i++)
            if (req_ready[i]) req_valid[i] = 1'b0;
        if (auto_eng) begin
            if (eng_start_w || eng_start_r) stop_cnt = 2;
            eng_stop = 1'b0;
            if (stop_cnt > 0) begin
                stop_cnt--;
                if (stop_cnt == 0) eng_stop = 1'b1;
            end
        end
        if (rereq0 && done[0]) begin
            req_valid[0] = 1'b1;
            u_addr[0]    = 12'd40;
            rereq0       = 0;
        end
    endtask

    task automatic step();
        predict();
        @(posedge clk);
        @(negedge clk);
        compare();
        react();
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; req_dir = '0; eng_stop = 1'b0; cpu_idle = 1'b0;
        auto_eng = 0; rereq0 = 0; stop_cnt = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    int order [4];
    int ng, cnt_hold, cnt_start, t_start, t_abort;
    bit seen;
    int a;

    initial begin
        for (int i = 0; i < NREQ; i++) begin u_blk[i] = '0; u_addr[i] = '0; end

        // Reset state and first OUT transfer on unit 1.
        do_reset();
        chk("rst_ctrl", 32'({req_ready, busy, done, err}), 32'd0);
        chk("rst_eng", 32'({cpu_hold, eng_start_w, eng_start_r, eng_abort}), 32'd0);
        chk("rst_latch", 32'({eng_block, eng_addr}), 32'd0);
        cpu_idle = 1'b1;
        u_blk[1] = 10'd5; u_addr[1] = 12'd100; req_dir = 4'b0010; req_valid = 4'b0010;
        step();
        chk("t1_ready", 32'(req_ready), 32'h2);
        chk("t1_busy", 32'(busy), 32'h2);
        step();
        chk("t1_nostart", 32'({eng_start_w, eng_start_r}), 32'd0);
        step();
        chk("t1_start_w", 32'(eng_start_w), 32'd1);
        chk("t1_block", 32'(eng_block), 32'd5);
        chk("t1_addr", 32'(eng_addr), 32'd100);
        step();
        eng_stop = 1'b1;
        step();
        eng_stop = 1'b0;
        chk("t1_done", 32'(done), 32'h2);
        chk("t1_busy_clr", 32'(busy), 32'h0);

        // Round-robin among units 0, 2, 3 with unit 0 re-requesting.
        do_reset();
        cpu_idle = 1'b1; auto_eng = 1; rereq0 = 1;
        for (int i = 0; i < NREQ; i++) u_addr[i] = 12'(i * 10);
        for (int i = 0; i < 4; i++) order[i] = -1;
        req_dir = 4'b0101; req_valid = 4'b1101;
        ng = 0;
        for (int n = 0; n < 200 && ng < 4; n++) begin
            step();
            for (int i = 0; i < NREQ; i++)
                if (req_ready[i] && ng < 4) begin order[ng] = i; ng++; end
        end
        chk("t2_count", 32'(ng), 32'd4);
        chk("t2_g0", 32'(order[0]), 32'd0);
        chk("t2_g1", 32'(order[1]), 32'd2);
        chk("t2_g2", 32'(order[2]), 32'd3);
        chk("t2_g3", 32'(order[3]), 32'd0);

        // Range check: 3901 rejected, 3900 accepted.
        do_reset();
        cpu_idle = 1'b1;
        u_addr[2] = 12'd3901; req_dir = 4'b0000; req_valid = 4'b0100;
        step();
        chk("t3_ready", 32'(req_ready), 32'h4);
        chk("t3_busy0", 32'(busy), 32'h0);
        step();
        chk("t3_err", 32'(err), 32'h4);
        chk("t3_busy1", 32'(busy), 32'h0);
        u_addr[2] = 12'd3900; req_valid = 4'b0100;
        step();
        chk("t3_ready_ok", 32'(req_ready), 32'h4);
        chk("t3_busy_ok", 32'(busy), 32'h4);
        auto_eng = 1; seen = 0;
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (done[2]) seen = 1;
        end
        chk("t3_done_seen", 32'(seen), 32'd1);

        // CPU slow to release the port.
        do_reset();
        u_addr[3] = 12'd0; req_dir = 4'b0000; req_valid = 4'b1000;
        step();
        chk("t4_ready", 32'(req_ready), 32'h8);
        cnt_hold = 0; cnt_start = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (cpu_hold) cnt_hold++;
            if (eng_start_w || eng_start_r) cnt_start++;
        end
        chk("t4_hold_cycles", 32'(cnt_hold), 32'd20);
        chk("t4_no_start", 32'(cnt_start), 32'd0);
        cpu_idle = 1'b1;
        step();
        chk("t4_start_r", 32'(eng_start_r), 32'd1);
        chk("t4_start_w", 32'(eng_start_w), 32'd0);

        // Reset while RUN, then a fresh request is arbitrated from unit 0.
        step();
        reset = 1'b1;
        step();
        chk("t5_ctrl", 32'({req_ready, busy, done, err}), 32'd0);
        chk("t5_eng", 32'({cpu_hold, eng_start_w, eng_start_r, eng_abort}), 32'd0);
        chk("t5_latch", 32'({eng_block, eng_addr}), 32'd0);
        reset = 1'b0;
        u_addr[0] = 12'd7; u_addr[2] = 12'd9; req_valid = 4'b0101;
        step();
        chk("t5_ready", 32'(req_ready), 32'h1);

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            cpu_idle = ($urandom_range(0, 3) != 0);
            eng_stop = ($urandom_range(0, 5) == 0);
            reset    = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 7) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       a = 3895 + int'($urandom_range(0, 10));
                        1:       a = int'($urandom_range(0, 4095));
                        default: a = int'($urandom_range(0, 3900));
                    endcase
                    u_addr[i]    = 12'(a);
                    u_blk[i]     = 10'($urandom_range(0, 1023));
                    req_dir[i]   = 1'($urandom_range(0, 1));
                    req_valid[i] = 1'b1;
                end
            end
            step();
        end

`ifdef SRAM_ARB_WATCHDOG_EN
        // Engine never stops: watchdog aborts after TIMEOUT RUN cycles.
        do_reset();
        cpu_idle = 1'b1; u_addr[1] = 12'd0; req_valid = 4'b0010;
        t_start = -1; t_abort = -1;
        for (int n = 0; n < TIMEOUT + 50 && t_abort < 0; n++) begin
            step();
            if (eng_start_w || eng_start_r) t_start = n;
            if (eng_abort) begin
                t_abort = n;
                chk("wd_err", 32'(err), 32'h2);
                chk("wd_busy", 32'(busy), 32'h0);
            end
        end
        chk("wd_gap", 32'(t_abort - t_start), 32'(TIMEOUT + 1));
        req_valid = 4'b0100;
        step();
        step();
        chk("wd_idle", 32'(req_ready), 32'h4);
`else
        t_start = 0; t_abort = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
